// File: rtl/dma_job_scheduler_if.sv
// Requester/engine-facing signal bundle of the DMA job scheduler.
// The scheduler uses the slave view; the environment drives through the master view.
interface dma_job_scheduler_if #(
  parameter int NUM_CH     = 4,
  parameter int ADDR_WIDTH = 32
);
  logic [NUM_CH-1:0]            i_req;
  logic [NUM_CH*ADDR_WIDTH-1:0] i_addr;
  logic [NUM_CH*32-1:0]         i_len;
  logic [NUM_CH-1:0]            o_ack;
  logic [NUM_CH-1:0]            o_ch_done;
  logic [NUM_CH-1:0]            o_ch_error;
  logic                         o_busy;
  logic                         o_hung;
  logic                         o_eng_start;
  logic [ADDR_WIDTH-1:0]        o_eng_base_addr;
  logic [31:0]                  o_eng_total_len;
  logic                         i_eng_done;
  logic                         i_eng_error;

  modport slave (
    input  i_req, i_addr, i_len, i_eng_done, i_eng_error,
    output o_ack, o_ch_done, o_ch_error, o_busy, o_hung,
           o_eng_start, o_eng_base_addr, o_eng_total_len
  );

  modport master (
    output i_req, i_addr, i_len, i_eng_done, i_eng_error,
    input  o_ack, o_ch_done, o_ch_error, o_busy, o_hung,
           o_eng_start, o_eng_base_addr, o_eng_total_len
  );
endinterface

// File: rtl/dma_job_scheduler.sv
// Round-robin job scheduler sharing one DMA engine between NUM_CH requesters,
// with alignment pre-check, start/done/error sequencing and a hang watchdog.
module dma_job_scheduler #(
  parameter int NUM_CH      = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int WDOG_CYCLES = 65536
) (
  input  logic               clk,
  input  logic               rst,
  dma_job_scheduler_if.slave bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int IW   = CH_W + 1;
  localparam int WD_W = $clog2(WDOG_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_START, S_WAIT, S_REPORT, S_HALT
  } state_t;

  state_t                state_q, state_d;
  logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           len_q, len_d;
  logic                  err_q, err_d;
  logic                  hung_q, hung_d;
  logic [WD_W-1:0]       wdog_q, wdog_d;
  logic [WD_W-1:0]       wdog_inc;

  logic [ADDR_WIDTH-1:0] req_addr [NUM_CH];
  logic [31:0]           req_len  [NUM_CH];

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
    assign req_addr[gi] = bus.i_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign req_len[gi]  = bus.i_len[gi*32 +: 32];
  end

  // First requesting channel at or above rr_ptr, wrapping modulo NUM_CH.
  logic            grant_vld;
  logic [CH_W-1:0] grant_ch;
  logic [IW-1:0]   idx;

  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    idx       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = {1'b0, rr_ptr_q} + IW'(i);
      if (idx >= IW'(NUM_CH)) begin
        idx = idx - IW'(NUM_CH);
      end
      if (!grant_vld && bus.i_req[idx[CH_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_ch  = idx[CH_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      ch_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      err_q    <= 1'b0;
      hung_q   <= 1'b0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      ch_q     <= ch_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      err_q    <= err_d;
      hung_q   <= hung_d;
      wdog_q   <= wdog_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    ch_d     = ch_q;
    addr_d   = addr_q;
    len_d    = len_q;
    err_d    = err_q;
    hung_d   = hung_q;
    wdog_d   = wdog_q;
    wdog_inc = wdog_q + WD_W'(1);
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          ch_d     = grant_ch;
          addr_d   = req_addr[grant_ch];
          len_d    = req_len[grant_ch];
          rr_ptr_d = (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + CH_W'(1);
          state_d  = S_CHECK;
        end
      end
      S_CHECK: begin
        // Illegal jobs are reported directly and never reach the engine.
        if ((addr_q[5:0] != 6'd0) || (len_q[1:0] != 2'd0) || (len_q == 32'd0)) begin
          err_d   = 1'b1;
          state_d = S_REPORT;
        end else begin
          err_d   = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        wdog_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wdog_d = wdog_inc;
        if (bus.i_eng_error) begin
          err_d   = 1'b1;
          state_d = S_REPORT;
        end else if (bus.i_eng_done) begin
          err_d   = 1'b0;
          state_d = S_REPORT;
        end else if (wdog_inc == WD_W'(WDOG_CYCLES - 1)) begin
          err_d   = 1'b1;
          hung_d  = 1'b1;
          state_d = S_REPORT;
        end
      end
      S_REPORT: state_d = hung_q ? S_HALT : S_IDLE;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  logic [NUM_CH-1:0] ch_onehot;

  always_comb begin
    ch_onehot           = '0;
    ch_onehot[ch_q]     = 1'b1;
    bus.o_ack           = (state_q == S_CHECK) ? ch_onehot : '0;
    bus.o_ch_done       = (state_q == S_REPORT) ? ch_onehot : '0;
    bus.o_ch_error      = (state_q == S_REPORT && err_q) ? ch_onehot : '0;
    bus.o_busy          = (state_q != S_IDLE);
    bus.o_hung          = hung_q;
    bus.o_eng_start     = (state_q == S_START);
    bus.o_eng_base_addr = addr_q;
    bus.o_eng_total_len = len_q;
  end
endmodule

// File: tb/tb_dma_job_scheduler.sv
// Scoreboard bench for dma_job_scheduler: directed jobs push expected ack/start/done
// entries, a negedge monitor pops and compares them, and a small engine model answers starts.
module tb_dma_job_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dma_job_scheduler_if #(.NUM_CH(4), .ADDR_WIDTH(32)) bus ();

  dma_job_scheduler #(.NUM_CH(4), .ADDR_WIDTH(32), .WDOG_CYCLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_ack = 0, n_start = 0, n_done = 0;
  int last_ack_cyc = 0, last_start_cyc = 0, last_done_cyc = 0;
  int eng_mode = 0;  // 0: done after 3 cycles, 1: done+error together, 2: never answers

  int          ack_q[$];
  logic [63:0] start_q[$];
  logic [4:0]  done_q[$];  // {err, ch}

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
    end
  endtask

  // Engine model: answers each start three cycles later according to eng_mode.
  initial begin
    bus.i_eng_done  = 1'b0;
    bus.i_eng_error = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && bus.o_eng_start && eng_mode != 2) begin
        repeat (3) @(posedge clk);
        #1;
        bus.i_eng_done  = 1'b1;
        bus.i_eng_error = (eng_mode == 1);
        @(posedge clk);
        #1;
        bus.i_eng_done  = 1'b0;
        bus.i_eng_error = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents ack, start or done.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_ack != '0) begin
        n_ack++;
        last_ack_cyc = cyc;
        if (ack_q.size() == 0) check("ack_unexpected", bus.o_ack, 0);
        else check("ack", bus.o_ack, 64'(1) << ack_q.pop_front());
      end
      if (bus.o_eng_start) begin
        n_start++;
        last_start_cyc = cyc;
        if (start_q.size() == 0) check("start_unexpected", 1, 0);
        else check("start_addr_len", {bus.o_eng_base_addr, bus.o_eng_total_len}, start_q.pop_front());
      end
      if (bus.o_ch_done != '0) begin
        logic [4:0] e;
        n_done++;
        last_done_cyc = cyc;
        if (done_q.size() == 0) begin
          check("done_unexpected", bus.o_ch_done, 0);
        end else begin
          e = done_q.pop_front();
          check("done", bus.o_ch_done, 64'(1) << e[3:0]);
          check("done_error", bus.o_ch_error, 64'(e[4]) << e[3:0]);
        end
      end else if (bus.o_ch_error != '0) begin
        check("error_without_done", bus.o_ch_error, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_job(input int ch, input logic [31:0] addr, input logic [31:0] len);
    bus.i_addr[ch*32 +: 32] = addr;
    bus.i_len[ch*32 +: 32]  = len;
  endtask

  task automatic wait_acks(input int target, input int budget, input string name);
    for (int k = 0; k < budget; k++) begin
      if (n_ack >= target) break;
      tick();
    end
    check(name, n_ack, target);
  endtask

  task automatic wait_starts(input int target, input int budget, input string name);
    for (int k = 0; k < budget; k++) begin
      if (n_start >= target) break;
      tick();
    end
    check(name, n_start, target);
  endtask

  task automatic wait_dones(input int target, input int budget, input string name);
    for (int k = 0; k < budget; k++) begin
      if (n_done >= target) break;
      tick();
    end
    check(name, n_done, target);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ack"},   bus.o_ack, 0);
    check({tag, "_done"},  bus.o_ch_done, 0);
    check({tag, "_error"}, bus.o_ch_error, 0);
    check({tag, "_busy"},  bus.o_busy, 0);
    check({tag, "_hung"},  bus.o_hung, 0);
    check({tag, "_start"}, bus.o_eng_start, 0);
    check({tag, "_addr"},  bus.o_eng_base_addr, 0);
    check({tag, "_len"},   bus.o_eng_total_len, 0);
  endtask

  // Single job on one channel; returns once the done pulse has been seen (or timed out).
  task automatic do_job(input int ch, input logic [31:0] addr, input logic [31:0] len,
                        input bit legal, input bit err, input int mode, input string tag,
                        output int t_req);
    int a0, d0;
    eng_mode = mode;
    ack_q.push_back(ch);
    if (legal) start_q.push_back({addr, len});
    done_q.push_back({err, 4'(ch)});
    a0 = n_ack;
    d0 = n_done;
    set_job(ch, addr, len);
    bus.i_req[ch] = 1'b1;
    t_req = cyc;
    wait_acks(a0 + 1, 20, {tag, "_ack_seen"});
    bus.i_req[ch] = 1'b0;
    wait_dones(d0 + 1, 60, {tag, "_done_seen"});
  endtask

  initial begin
    int t, s0, a0, d0;
    bus.i_req  = '0;
    bus.i_addr = '0;
    bus.i_len  = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #2;
    check_outputs_zero("in_reset");
    rst = 1'b0;
    tick();
    check_outputs_zero("after_reset");

    // Legal job on ch0
    do_job(0, 32'h1000, 32'd256, 1'b1, 1'b0, 0, "legal_ch0", t);
    check("legal_ack_latency", last_ack_cyc - t, 1);
    check("legal_start_latency", last_start_cyc - t, 2);
    check("legal_done_after_start", last_done_cyc - last_start_cyc, 4);
    check("legal_idle_after_done", bus.o_busy, 0);
    check("legal_addr_held", bus.o_eng_base_addr, 32'h1000);
    check("legal_len_held", bus.o_eng_total_len, 32'd256);

    // Misaligned / empty jobs on ch2: never start the engine
    s0 = n_start;
    do_job(2, 32'h1004, 32'd64, 1'b0, 1'b1, 0, "bad_addr", t);
    check("bad_addr_done_latency", last_done_cyc - t, 2);
    check("bad_addr_idle", bus.o_busy, 0);
    do_job(2, 32'h1000, 32'd66, 1'b0, 1'b1, 0, "bad_len", t);
    check("bad_len_done_latency", last_done_cyc - t, 2);
    do_job(2, 32'h1000, 32'd0, 1'b0, 1'b1, 0, "zero_len", t);
    check("zero_len_done_latency", last_done_cyc - t, 2);
    check("misaligned_no_start", n_start, s0);

    // Done and error in the same WAIT cycle on ch3: error wins
    do_job(3, 32'h1040, 32'd128, 1'b1, 1'b1, 1, "both_ch3", t);

    // All four channels requesting continuously: grants 0,1,2,3,0
    eng_mode = 0;
    for (int k = 0; k < 4; k++) set_job(k, 32'h2000 + 32'(k) * 32'h40, 32'd64 * 32'(k + 1));
    for (int k = 0; k < 5; k++) begin
      ack_q.push_back(k % 4);
      start_q.push_back({32'h2000 + 32'(k % 4) * 32'h40, 32'd64 * 32'((k % 4) + 1)});
      done_q.push_back({1'b0, 4'(k % 4)});
    end
    a0 = n_ack;
    d0 = n_done;
    bus.i_req = 4'b1111;
    wait_acks(a0 + 5, 200, "rr_five_acks");
    bus.i_req = 4'b0000;
    wait_dones(d0 + 5, 200, "rr_five_dones");

    // Watchdog: engine never answers
    do_job(1, 32'h3000, 32'd128, 1'b1, 1'b1, 2, "wdog_ch1", t);
    check("wdog_done_after_start", last_done_cyc - last_start_cyc, 16);
    check("wdog_hung", bus.o_hung, 1);
    check("wdog_busy", bus.o_busy, 1);
    a0 = n_ack;
    bus.i_req = 4'b1111;
    repeat (30) tick();
    check("halt_no_ack", n_ack, a0);
    check("halt_still_hung", bus.o_hung, 1);
    check("halt_still_busy", bus.o_busy, 1);
    bus.i_req = 4'b0000;

    // Reset clears the halt
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check_outputs_zero("halt_reset");

    // Reset in WAIT aborts the job without a done pulse
    eng_mode = 2;
    ack_q.push_back(2);
    start_q.push_back({32'h4000, 32'd32});
    set_job(2, 32'h4000, 32'd32);
    a0 = n_ack;
    s0 = n_start;
    d0 = n_done;
    bus.i_req[2] = 1'b1;
    wait_acks(a0 + 1, 20, "abort_ack_seen");
    bus.i_req[2] = 1'b0;
    wait_starts(s0 + 1, 20, "abort_start_seen");
    repeat (2) tick();
    check("abort_busy_before", bus.o_busy, 1);
    rst = 1'b1;
    #1;
    check_outputs_zero("abort_async");
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    check("abort_no_done", n_done, d0);

    // After reset rr_ptr is 0, so ch1 wins over ch3
    eng_mode = 0;
    set_job(1, 32'h5000, 32'd16);
    set_job(3, 32'h6000, 32'd16);
    ack_q.push_back(1);
    start_q.push_back({32'h5000, 32'd16});
    done_q.push_back({1'b0, 4'd1});
    a0 = n_ack;
    d0 = n_done;
    bus.i_req = 4'b1010;
    t = cyc;
    wait_acks(a0 + 1, 20, "post_reset_ack_seen");
    bus.i_req = 4'b0000;
    check("post_reset_ack_latency", last_ack_cyc - t, 1);
    wait_dones(d0 + 1, 60, "post_reset_done_seen");

    check("ack_queue_drained", ack_q.size(), 0);
    check("start_queue_drained", start_q.size(), 0);
    check("done_queue_drained", done_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got cycle %0d required completion", cyc);
    $fatal(1, "timeout");
  end
endmodule
